fp_align_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational floating-point magnitude-compare stage at the front of the FP adder.
- Accepts two IEEE-style operands plus an add/sub opcode and identifies the larger-magnitude operand.
- Inserts hidden bits, right-aligns the smaller mantissa with guard/round/sticky bits, and resolves the effective operation and the result sign.
- Feeds the mantissa add/normalise stage through a valid/ready handshake, with a fixed 2-cycle latency.

---
 rtl/fp_align_pipe.sv | 186 ++++++++++++++++++
 tb/tb_fp_align_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_align_pipe.sv
// fp_align_pipe: two-stage front end of the floating-point adder.
// S1 compares operand magnitudes, picks the larger one and works out the effective
// operation and result sign. S2 right-aligns the smaller mantissa with guard, round
// and sticky bits. The stages are linked by a valid/ready handshake with 2-cycle latency.
module fp_align_pipe #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W,
  localparam int AW    = MAN_W + 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] l_exp,
  output logic [AW-1:0]    l_man,
  output logic [AW-1:0]    s_man,
  output logic             eff_sub,
  output logic             res_sign,
  output logic             swap,
  output logic             equal,
  output logic             zero_result,
  output logic             special
);

  // ---------------------------------------------------------------------------
  // Operand field split
  // ---------------------------------------------------------------------------
  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] man_a, man_b;
  logic [W-2:0]     mag_a, mag_b;
  logic             hid_a, hid_b;
  logic [EXP_W-1:0] eexp_a, eexp_b;

  assign sign_a = a[W-1];
  assign sign_b = b[W-1];
  assign exp_a  = a[W-2 -: EXP_W];
  assign exp_b  = b[W-2 -: EXP_W];
  assign man_a  = a[MAN_W-1:0];
  assign man_b  = b[MAN_W-1:0];
  assign mag_a  = a[W-2:0];
  assign mag_b  = b[W-2:0];

  // A denormal has no hidden bit but sits at the same scale as exponent 1.
  assign hid_a  = |exp_a;
  assign hid_b  = |exp_b;
  assign eexp_a = hid_a ? exp_a : EXP_W'(1);
  assign eexp_b = hid_b ? exp_b : EXP_W'(1);

  // ---------------------------------------------------------------------------
  // S1 combinational compare
  // ---------------------------------------------------------------------------
  logic             swap_c, equal_c, eff_sub_c, zero_c, res_sign_c, special_c;
  logic [EXP_W-1:0] l_exp_c, diff_c;
  logic [AW-1:0]    l_man_c, s_unsh_c;

  assign swap_c     = mag_b > mag_a;
  assign equal_c    = mag_a == mag_b;
  assign eff_sub_c  = sign_a ^ sign_b ^ op_sub;
  assign zero_c     = equal_c & eff_sub_c;
  assign res_sign_c = zero_c ? 1'b0 : (swap_c ? (sign_b ^ op_sub) : sign_a);
  assign special_c  = (&exp_a) | (&exp_b);

  // Route the larger operand to the l_* path and the smaller one to the shifter.
  // The larger magnitude never has the smaller effective exponent, so diff is non-negative.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    l_exp_c  = eexp_a;
    l_man_c  = {hid_a, man_a, 3'b000};
    s_unsh_c = {hid_b, man_b, 3'b000};
    diff_c   = eexp_a - eexp_b;
    if (swap_c) begin
      l_exp_c  = eexp_b;
      l_man_c  = {hid_b, man_b, 3'b000};
      s_unsh_c = {hid_a, man_a, 3'b000};
      diff_c   = eexp_b - eexp_a;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers and handshake
  // ---------------------------------------------------------------------------
  logic             s1_valid, s2_valid;
  logic             s2_load;
  logic [EXP_W-1:0] s1_l_exp, s1_diff;
  logic [AW-1:0]    s1_l_man, s1_s_unsh;
  logic             s1_eff_sub, s1_res_sign, s1_swap, s1_equal, s1_zero, s1_special;

  // S2 takes new data whenever its current content leaves or it holds nothing.
  assign s2_load  = !s2_valid | out_ready;
  assign in_ready = !s1_valid | s2_load;

  // ---------------------------------------------------------------------------
  // S2 combinational barrel shift with sticky collection
  // ---------------------------------------------------------------------------
  logic [AW-1:0] shifted, aligned;
  logic [31:0]   diff_ext;
  logic          sticky;

  assign diff_ext = 32'(s1_diff);
  assign shifted  = s1_s_unsh >> s1_diff;
  // Any bit lost by the shift shows up as a difference after shifting back.
  assign sticky   = (shifted << s1_diff) != s1_s_unsh;

  // Fold the lost bits into the LSB; a shift past the whole field leaves only sticky.
  always_comb begin
    aligned = {shifted[AW-1:1], shifted[0] | sticky};
    if (diff_ext >= 32'(AW)) begin
      aligned = {{(AW-1){1'b0}}, |s1_s_unsh};
    end
  end

  // S1 captures compare results whenever it can accept an operand pair.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: data registers are cleared too, because the outputs must read zero
      // straight after reset, not just be flagged invalid.
      s1_valid    <= 1'b0;
      s1_l_exp    <= '0;
      s1_diff     <= '0;
      s1_l_man    <= '0;
      s1_s_unsh   <= '0;
      s1_eff_sub  <= 1'b0;
      s1_res_sign <= 1'b0;
      s1_swap     <= 1'b0;
      s1_equal    <= 1'b0;
      s1_zero     <= 1'b0;
      s1_special  <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_l_exp    <= l_exp_c;
        s1_diff     <= diff_c;
        s1_l_man    <= l_man_c;
        s1_s_unsh   <= s_unsh_c;
        s1_eff_sub  <= eff_sub_c;
        s1_res_sign <= res_sign_c;
        s1_swap     <= swap_c;
        s1_equal    <= equal_c;
        s1_zero     <= zero_c;
        s1_special  <= special_c;
      end
    end
  end

  // S2 captures the aligned result and holds it while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid    <= 1'b0;
      l_exp       <= '0;
      l_man       <= '0;
      s_man       <= '0;
      eff_sub     <= 1'b0;
      res_sign    <= 1'b0;
      swap        <= 1'b0;
      equal       <= 1'b0;
      zero_result <= 1'b0;
      special     <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        l_exp       <= s1_l_exp;
        l_man       <= s1_l_man;
        s_man       <= aligned;
        eff_sub     <= s1_eff_sub;
        res_sign    <= s1_res_sign;
        swap        <= s1_swap;
        equal       <= s1_equal;
        zero_result <= s1_zero;
        special     <= s1_special;
      end
    end
  end

  assign out_valid = s2_valid;

endmodule

// File: tb/tb_fp_align_pipe.sv
// Scoreboard bench for fp_align_pipe (EXP_W=8, MAN_W=23): the driver pushes the
// hand-computed response of each accepted pair, and a monitor pops and compares
// whenever the DUT hands a result downstream.
module tb_fp_align_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  l_exp;
  logic [26:0] l_man, s_man;
  logic        eff_sub, res_sign, swap, equal, zero_result, special;

  fp_align_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .l_exp(l_exp), .l_man(l_man), .s_man(s_man),
    .eff_sub(eff_sub), .res_sign(res_sign), .swap(swap),
    .equal(equal), .zero_result(zero_result), .special(special)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  l_exp;
    logic [26:0] l_man;
    logic [26:0] s_man;
    logic        eff_sub;
    logic        res_sign;
    logic        swap;
    logic        equal;
    logic        zero_result;
    logic        special;
  } resp_t;

  resp_t sb[$];
  int    errors = 0;
  int    checks = 0;
  int    n_out  = 0;
  resp_t cur;

  assign cur = '{l_exp, l_man, s_man, eff_sub, res_sign, swap, equal, zero_result, special};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic resp_t mk(input logic [7:0] le, input logic [26:0] lm, input logic [26:0] sm,
                               input logic es, input logic rs, input logic sw,
                               input logic eq, input logic zr, input logic sp);
    mk = '{le, lm, sm, es, rs, sw, eq, zr, sp};
  endfunction

  // Monitor: every handshake on the output side retires one scoreboard entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: result %0d got %0h expected none", n_out, cur);
      end else begin
        resp_t e;
        e = sb.pop_front();
        check($sformatf("r%0d.l_exp", n_out),    l_exp,       e.l_exp);
        check($sformatf("r%0d.l_man", n_out),    l_man,       e.l_man);
        check($sformatf("r%0d.s_man", n_out),    s_man,       e.s_man);
        check($sformatf("r%0d.flags", n_out),
              {eff_sub, res_sign, swap, equal, zero_result, special},
              {e.eff_sub, e.res_sign, e.swap, e.equal, e.zero_result, e.special});
      end
      n_out++;
    end
  end

  // Present a pair just after a rising edge; once in_ready is seen the pair
  // transfers at the next rising edge, so its response is queued now.
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic top, input resp_t e);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    a        = ta;
    b        = tb_v;
    op_sub   = top;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    sb.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, sb.size(), 0);
  endtask

  // After a send+idle, the result must be absent one cycle later and present the next.
  task automatic latency(input string name);
    @(negedge clk);
    check({name, "_lat1"}, out_valid, 1'b0);
    @(negedge clk);
    check({name, "_lat2"}, out_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resp_t r_t1, r_t2, r_t3, r_d40, r_den, r_inf, r_neg, r_two, r_m3;
    resp_t snap;

    //                 l_exp  l_man       s_man      es rs sw eq zr sp
    r_t1  = mk(8'h80, 27'h6000000, 27'h2000000, 0, 0, 0, 0, 0, 0);
    r_t2  = mk(8'h97, 27'h4000000, 27'h0000005, 0, 0, 1, 0, 0, 0);
    r_t3  = mk(8'h7F, 27'h4000000, 27'h4000000, 1, 0, 0, 1, 1, 0);
    r_d40 = mk(8'hA7, 27'h4000000, 27'h0000001, 0, 0, 0, 0, 0, 0);
    r_den = mk(8'h01, 27'h4000000, 27'h0000008, 0, 0, 0, 0, 0, 0);
    r_inf = mk(8'hFF, 27'h4000000, 27'h0000001, 0, 0, 0, 0, 0, 1);
    r_neg = mk(8'h80, 27'h4000000, 27'h2000000, 1, 1, 1, 0, 0, 0);
    r_two = mk(8'h80, 27'h4000000, 27'h2000000, 0, 0, 0, 0, 0, 0);
    r_m3  = mk(8'h80, 27'h6000000, 27'h2000000, 1, 1, 0, 0, 0, 0);

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op_sub    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_outputs",   cur,       '0);
    check("rst_in_ready",  in_ready,  1'b1);

    // 1: 3.0 + 1.0 with latency check
    send(32'h40400000, 32'h3F800000, 1'b0, r_t1);
    idle();
    latency("t1");
    drain("t1_drain");

    // 2-4 plus infinity and a swapped subtraction, back to back
    send(32'h3F800001, 32'h4B800000, 1'b0, r_t2);
    send(32'h3F800000, 32'hBF800000, 1'b0, r_t3);
    send(32'h3F800000, 32'h3F800000, 1'b1, r_t3);
    send(32'h53800000, 32'h3F800000, 1'b0, r_d40);
    send(32'h00800000, 32'h00000001, 1'b0, r_den);
    send(32'h7F800000, 32'h3F800000, 1'b0, r_inf);
    send(32'h3F800000, 32'h40000000, 1'b1, r_neg);
    idle();
    drain("t2_4_drain");

    // 5: stream of four with a 3-cycle downstream stall after the first out_valid
    fork
      begin
        send(32'h40400000, 32'h3F800000, 1'b0, r_t1);
        send(32'h3F800001, 32'h4B800000, 1'b0, r_t2);
        send(32'h40000000, 32'h3F800000, 1'b0, r_two);
        send(32'hC0400000, 32'h3F800000, 1'b0, r_m3);
        idle();
      end
      begin
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!out_valid && n < 50) begin
          @(posedge clk); #1;
          n++;
        end
        out_ready = 1'b0;
        snap = cur;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check($sformatf("t5_hold%0d", i),     cur,       snap);
          check($sformatf("t5_valid%0d", i),    out_valid, 1'b1);
          check($sformatf("t5_in_ready%0d", i), in_ready,  1'b0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain("t5_drain");

    // 6: reset with two transactions in flight
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    a        = 32'h40400000;
    b        = 32'h3F800000;
    op_sub   = 1'b0;
    @(posedge clk); #1;
    a        = 32'h53800000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_outputs",   cur,       '0);
    check("t6_in_ready",  in_ready,  1'b1);
    send(32'h00800000, 32'h00000001, 1'b0, r_den);
    idle();
    latency("t6");
    drain("t6_drain");

    repeat (4) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
